// File: rtl/reveal_sequencer.sv
// Board-memory sequencer for player actions: single reveal, flag toggle and
// breadth-first flood fill of zero-count regions through one RAM port.
module reveal_sequencer #(
  parameter int GRID_W     = 15,
  parameter int GRID_H     = 15,
  parameter int NUM_MINES  = 30,
  parameter int FIFO_DEPTH = 256
) (
  input  logic       clk_pix,
  input  logic       sim_rst,
  input  logic       cell_click,
  input  logic       right_click,
  input  logic [3:0] clicked_cell_x,
  input  logic [3:0] clicked_cell_y,
  input  logic       restart_game,
  output logic [7:0] mem_addr,
  output logic       mem_we,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  output logic       busy,
  output logic       game_over,
  output logic       game_won,
  output logic [7:0] revealed_count,
  output logic [7:0] flag_count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [7:0]        WIN_CNT = 8'(GRID_W * GRID_H - NUM_MINES);
  localparam logic [4:0]        GW_U    = 5'(GRID_W);
  localparam logic [4:0]        GH_U    = 5'(GRID_H);
  localparam logic signed [4:0] GW_S    = 5'(GRID_W);
  localparam logic signed [4:0] GH_S    = 5'(GRID_H);

  typedef enum logic [2:0] {IDLE, C_RD, C_EV, POP, N_RD, N_EV} state_t;

  state_t        state_q, state_d;
  logic [3:0]    x_q, x_d, y_q, y_d, cx_q, cx_d, cy_q, cy_d;
  logic          op_rev_q, op_rev_d;
  logic [2:0]    k_q, k_d;
  logic [7:0]    rev_q, rev_d, flag_q, flag_d;
  logic          over_q, over_d, won_q, won_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic          push, pop;
  logic [7:0]    push_data, head;
  logic [3:0]    fv;
  logic signed [4:0] nx, ny;

  function automatic logic signed [4:0] off_x(input logic [2:0] k);
    case (k)
      3'd0, 3'd3, 3'd5: off_x = -5'sd1;
      3'd1, 3'd6:       off_x = 5'sd0;
      default:          off_x = 5'sd1;
    endcase
  endfunction

  function automatic logic signed [4:0] off_y(input logic [2:0] k);
    if (k < 3'd3)      off_y = -5'sd1;
    else if (k < 3'd5) off_y = 5'sd0;
    else               off_y = 5'sd1;
  endfunction

  function automatic logic in_bounds(input logic signed [4:0] px, input logic signed [4:0] py);
    in_bounds = (px >= 5'sd0) && (px < GW_S) && (py >= 5'sd0) && (py < GH_S);
  endfunction

  // Lowest neighbour index >= start that lies on the board; bit 3 = found.
  // Off-board neighbours are skipped here so they cost no cycles.
  function automatic logic [3:0] first_valid(input logic [3:0] px, input logic [3:0] py,
                                             input logic [3:0] start);
    first_valid = 4'd0;
    for (int j = 7; j >= 0; j--) begin
      if (4'(j) >= start &&
          in_bounds($signed({1'b0, px}) + off_x(3'(j)), $signed({1'b0, py}) + off_y(3'(j))))
        first_valid = {1'b1, 3'(j)};
    end
  endfunction

  function automatic logic [7:0] cell_addr(input logic [3:0] px, input logic [3:0] py);
    cell_addr = 8'(py) * 8'(GRID_W) + 8'(px);
  endfunction

  assign head = fifo_mem[rd_ptr_q];
  assign nx   = $signed({1'b0, cx_q}) + off_x(k_q);
  assign ny   = $signed({1'b0, cy_q}) + off_y(k_q);

  always_comb begin
    state_d = state_q; x_d = x_q; y_d = y_q; cx_d = cx_q; cy_d = cy_q;
    op_rev_d = op_rev_q; k_d = k_q; rev_d = rev_q; flag_d = flag_q;
    over_d = over_q; won_d = won_q | (rev_q == WIN_CNT);
    push = 1'b0; pop = 1'b0; push_data = 8'd0; fv = 4'd0;
    mem_addr = 8'd0; mem_we = 1'b0; mem_wdata = mem_rdata;
    case (state_q)
      IDLE: begin
        if ((cell_click || right_click) && !over_q && !won_q &&
            ({1'b0, clicked_cell_x} < GW_U) && ({1'b0, clicked_cell_y} < GH_U)) begin
          x_d = clicked_cell_x; y_d = clicked_cell_y; op_rev_d = cell_click;
          state_d = C_RD;
        end
      end
      C_RD: begin
        mem_addr = cell_addr(x_q, y_q);
        state_d  = C_EV;
      end
      C_EV: begin
        mem_addr = cell_addr(x_q, y_q);
        state_d  = IDLE;
        if (!op_rev_q) begin
          if (!mem_rdata[6]) begin
            mem_we    = 1'b1;
            mem_wdata = mem_rdata ^ 8'h20;
            flag_d    = mem_rdata[5] ? flag_q - 8'd1 : flag_q + 8'd1;
          end
        end else if (!mem_rdata[6] && !mem_rdata[5]) begin
          mem_we    = 1'b1;
          mem_wdata = mem_rdata | 8'h40;
          if (mem_rdata[7]) over_d = 1'b1;
          else begin
            rev_d = rev_q + 8'd1;
            if (mem_rdata[3:0] == 4'd0) begin
              push = 1'b1; push_data = {y_q, x_q}; state_d = POP;
            end
          end
        end
      end
      POP: begin
        if (cnt_q == '0) state_d = IDLE;
        else begin
          pop = 1'b1;
          cx_d = head[3:0]; cy_d = head[7:4];
          fv = first_valid(head[3:0], head[7:4], 4'd0);
          k_d = fv[2:0];
          state_d = fv[3] ? N_RD : POP;
        end
      end
      N_RD: begin
        mem_addr = cell_addr(nx[3:0], ny[3:0]);
        state_d  = N_EV;
      end
      N_EV: begin
        mem_addr = cell_addr(nx[3:0], ny[3:0]);
        if (in_bounds(nx, ny) && !mem_rdata[7] && !mem_rdata[6] && !mem_rdata[5]) begin
          mem_we    = 1'b1;
          mem_wdata = mem_rdata | 8'h40;
          rev_d     = rev_q + 8'd1;
          if (mem_rdata[3:0] == 4'd0) begin
            push = 1'b1; push_data = {ny[3:0], nx[3:0]};
          end
        end
        fv = first_valid(cx_q, cy_q, {1'b0, k_q} + 4'd1);
        k_d = fv[2:0];
        state_d = fv[3] ? N_RD : POP;
      end
      default: state_d = IDLE;
    endcase

    wr_ptr_d = wr_ptr_q; rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    cnt_d = cnt_q + CW'(push) - CW'(pop);

    // Restart overrides everything, including a write the fill wanted this cycle.
    if (restart_game) begin
      state_d = IDLE; rev_d = 8'd0; flag_d = 8'd0; over_d = 1'b0; won_d = 1'b0;
      wr_ptr_d = '0; rd_ptr_d = '0; cnt_d = '0;
      mem_we = 1'b0; mem_addr = 8'd0; push = 1'b0;
    end
  end

  always_ff @(posedge clk_pix) begin
    if (sim_rst) begin
      state_q <= IDLE; x_q <= '0; y_q <= '0; cx_q <= '0; cy_q <= '0;
      op_rev_q <= 1'b0; k_q <= '0; rev_q <= '0; flag_q <= '0;
      over_q <= 1'b0; won_q <= 1'b0; wr_ptr_q <= '0; rd_ptr_q <= '0; cnt_q <= '0;
    end else begin
      state_q <= state_d; x_q <= x_d; y_q <= y_d; cx_q <= cx_d; cy_q <= cy_d;
      op_rev_q <= op_rev_d; k_q <= k_d; rev_q <= rev_d; flag_q <= flag_d;
      over_q <= over_d; won_q <= won_d; wr_ptr_q <= wr_ptr_d; rd_ptr_q <= rd_ptr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_pix) begin
    if (push) fifo_mem[wr_ptr_q] <= push_data;
  end

  assert property (@(posedge clk_pix) disable iff (sim_rst) !(push && cnt_q == CW'(FIFO_DEPTH)));

  assign busy           = (state_q != IDLE);
  assign game_over      = over_q;
  assign game_won       = won_q;
  assign revealed_count = rev_q;
  assign flag_count     = flag_q;
endmodule

// File: tb/tb_reveal_sequencer.sv
// Directed bench: bench-owned board RAM, BFS reference model of the game rules,
// per-cycle write/status checking plus hand-computed literal expectations.
module tb_reveal_sequencer;
  localparam int W = 15, H = 15, NM = 30, N = W * H;

  logic clk_pix = 1'b0, sim_rst = 1'b1;
  logic cell_click = 1'b0, right_click = 1'b0, restart_game = 1'b0;
  logic [3:0] cx = 4'd0, cy = 4'd0;
  logic [7:0] mem_addr, mem_wdata, mem_rdata, revealed_count, flag_count;
  logic mem_we, busy, game_over, game_won;

  reveal_sequencer #(.GRID_W(W), .GRID_H(H), .NUM_MINES(NM), .FIFO_DEPTH(256)) dut (
    .clk_pix(clk_pix), .sim_rst(sim_rst), .cell_click(cell_click), .right_click(right_click),
    .clicked_cell_x(cx), .clicked_cell_y(cy), .restart_game(restart_game),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .game_over(game_over), .game_won(game_won),
    .revealed_count(revealed_count), .flag_count(flag_count));

  always #5 clk_pix = ~clk_pix;

  logic [7:0] ram [N];
  logic [7:0] load_img [N];
  logic       load_go = 1'b0;
  always @(posedge clk_pix) begin
    if (load_go) for (int i = 0; i < N; i++) ram[i] <= load_img[i];
    else if (mem_we && mem_addr < N) ram[mem_addr] <= mem_wdata;
    mem_rdata <= (mem_addr < N) ? ram[mem_addr] : 8'h00;
  end

  // reference model
  logic [7:0] mb [N];
  bit   mine_m [N];
  int   m_rev = 0, m_flag = 0;
  bit   m_over = 0, m_won = 0, m_valid = 0;
  int   checks = 0, errors = 0;
  int   gen = 1;
  int   wgen [N];
  int   nwr;
  bit   busy_seen, addr_nz;
  logic [7:0] last_wa, last_wd;

  // Every write must be a legal reveal (once per cell per board, never a flagged
  // cell, other bits preserved) or a flag toggle of an unrevealed cell.
  always @(negedge clk_pix) begin
    logic ok;
    if (mem_we) begin
      checks++;
      if (mem_addr >= N) begin
        errors++; $display("FAIL wr_range addr=%0d max=%0d", mem_addr, N - 1);
      end else begin
        if (mem_wdata[6]) begin
          ok = !ram[mem_addr][6] && !ram[mem_addr][5] && (wgen[mem_addr] != gen) &&
               (mem_wdata == (ram[mem_addr] | 8'h40));
          wgen[mem_addr] = gen;
        end else ok = !ram[mem_addr][6] && (mem_wdata == (ram[mem_addr] ^ 8'h20));
        if (!ok) begin
          errors++;
          $display("FAIL wr_legal addr=%0d data=%02h old=%02h", mem_addr, mem_wdata, ram[mem_addr]);
        end
      end
    end
    if (m_valid && !busy) begin
      checks++;
      if (revealed_count !== m_rev[7:0] || flag_count !== m_flag[7:0] || game_over !== m_over ||
          game_won !== m_won || mem_we !== 1'b0) begin
        errors++;
        $display("FAIL idle_status got rev=%0d flag=%0d over=%0b won=%0b we=%0b exp rev=%0d flag=%0d over=%0b won=%0b we=0",
                 revealed_count, flag_count, game_over, game_won, mem_we, m_rev, m_flag, m_over, m_won);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin errors++; $display("FAIL %s got=%0h exp=%0h", nm, act, exp); end
  endtask

  task automatic chk_ram(input string nm);
    int bad;
    bad = -1;
    for (int i = 0; i < N; i++) if (ram[i] !== mb[i] && bad < 0) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++; $display("FAIL %s addr=%0d got=%02h exp=%02h", nm, bad, ram[bad], mb[bad]);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_pix);
  endtask

  task automatic clear_mines();
    for (int i = 0; i < N; i++) mine_m[i] = 0;
  endtask

  task automatic load_board();
    int c;
    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) begin
      c = 0;
      for (int dy = -1; dy <= 1; dy++) for (int dx = -1; dx <= 1; dx++)
        if ((dx != 0 || dy != 0) && x + dx >= 0 && x + dx < W && y + dy >= 0 && y + dy < H &&
            mine_m[(y + dy) * W + x + dx]) c++;
      load_img[y * W + x] = {mine_m[y * W + x], 2'b00, ((y * W + x) % 11 == 5), 4'(c)};
      mb[y * W + x] = load_img[y * W + x];
    end
    load_go = 1'b1;
    @(posedge clk_pix); #1 load_go = 1'b0;
    @(negedge clk_pix);
    gen++;
  endtask

  task automatic model_reveal(input int x, input int y);
    int q[$];
    int c, i, nx, ny, ni;
    if (m_over || m_won || x >= W || y >= H) return;
    i = y * W + x;
    if (mb[i][6] || mb[i][5]) return;
    mb[i][6] = 1'b1;
    if (mb[i][7]) begin m_over = 1; return; end
    m_rev++;
    if (mb[i][3:0] == 0) q.push_back(i);
    while (q.size() > 0) begin
      c = q.pop_front();
      for (int dy = -1; dy <= 1; dy++) for (int dx = -1; dx <= 1; dx++) begin
        nx = c % W + dx; ny = c / W + dy;
        if ((dx != 0 || dy != 0) && nx >= 0 && nx < W && ny >= 0 && ny < H) begin
          ni = ny * W + nx;
          if (mb[ni][7:5] == 3'b000) begin
            mb[ni][6] = 1'b1; m_rev++;
            if (mb[ni][3:0] == 0) q.push_back(ni);
          end
        end
      end
    end
    if (m_rev == N - NM) m_won = 1;
  endtask

  task automatic model_flag(input int x, input int y);
    int i;
    if (m_over || m_won || x >= W || y >= H) return;
    i = y * W + x;
    if (mb[i][6]) return;
    mb[i][5] = ~mb[i][5];
    m_flag = mb[i][5] ? m_flag + 1 : m_flag - 1;
  endtask

  task automatic do_click(input bit rev, input int x, input int y, input int maxc);
    int n;
    m_valid = 0; nwr = 0; busy_seen = 0; addr_nz = 0;
    cx = 4'(x); cy = 4'(y); cell_click = rev; right_click = !rev;
    @(negedge clk_pix);
    cell_click = 1'b0; right_click = 1'b0;
    n = 0;
    while (busy && n < maxc) begin
      busy_seen = 1;
      if (mem_addr != 0) addr_nz = 1;
      if (mem_we) begin nwr++; last_wa = mem_addr; last_wd = mem_wdata; end
      @(negedge clk_pix); n++;
    end
    if (mem_addr != 0) addr_nz = 1;
    chk("op_done_in_budget", {31'd0, busy}, 0);
    tick(2);
    if (rev) model_reveal(x, y); else model_flag(x, y);
    chk_ram("ram_image");
    m_valid = 1;
  endtask

  task automatic do_restart();
    m_valid = 0;
    restart_game = 1'b1;
    @(negedge clk_pix);
    restart_game = 1'b0;
    m_rev = 0; m_flag = 0; m_over = 0; m_won = 0;
  endtask

  initial begin
    tick(3);
    sim_rst = 1'b0;
    chk("rst_addr", mem_addr, 0);   chk("rst_we", mem_we, 0);     chk("rst_busy", busy, 0);
    chk("rst_over", game_over, 0);  chk("rst_won", game_won, 0);
    chk("rst_rev", revealed_count, 0); chk("rst_flag", flag_count, 0);

    // board A: mines (0,0),(2,5),(4,5)
    clear_mines(); mine_m[0] = 1; mine_m[5 * W + 2] = 1; mine_m[5 * W + 4] = 1;
    load_board();
    m_valid = 1;
    m_valid = 0;
    cx = 4'd3; cy = 4'd4; cell_click = 1'b1;
    @(negedge clk_pix); cell_click = 1'b0;
    chk("rv_addr_c1", mem_addr, 63); chk("rv_busy_c1", busy, 1); chk("rv_we_c1", mem_we, 0);
    @(negedge clk_pix);
    chk("rv_we_c2", mem_we, 1); chk("rv_wdata_c2", mem_wdata, 8'h42); chk("rv_addr_c2", mem_addr, 63);
    @(negedge clk_pix);
    chk("rv_busy_c3", busy, 0); chk("rv_count_c3", revealed_count, 1);
    model_reveal(3, 4); tick(1); chk_ram("ram_image"); m_valid = 1;

    do_click(0, 5, 5, 20);
    chk("flag1_addr", last_wa, 80); chk("flag1_data", last_wd, 8'h21); chk("flag1_cnt", flag_count, 1);
    do_click(0, 5, 5, 20);
    chk("flag2_addr", last_wa, 80); chk("flag2_data", last_wd, 8'h01); chk("flag2_cnt", flag_count, 0);
    do_click(0, 3, 4, 20);
    chk("flag_revealed_nowr", nwr, 0);
    do_click(1, 15, 2, 20);
    chk("x15_drop_busy", busy_seen, 0);
    do_click(1, 2, 15, 20);
    chk("y15_drop_busy", busy_seen, 0);

    do_click(1, 0, 0, 20);
    chk("mine_addr", last_wa, 0); chk("mine_data", last_wd, 8'hC0); chk("mine_over", game_over, 1);
    do_click(1, 1, 1, 20);
    chk("over_drop_busy", busy_seen, 0); chk("over_drop_addr", addr_nz, 0);

    // board B: corner walled off by mines on column 4 and row 4; (1,1) flagged
    do_restart(); tick(1);
    chk("restart_over", game_over, 0); chk("restart_rev", revealed_count, 0);
    clear_mines();
    for (int i = 0; i <= 4; i++) mine_m[i * W + 4] = 1;
    for (int i = 0; i <= 3; i++) mine_m[4 * W + i] = 1;
    load_board(); m_valid = 1;
    do_click(0, 1, 1, 20);
    do_click(1, 0, 0, 500);
    chk("corner_rev_literal", revealed_count, 15); chk("corner_flag", flag_count, 1);

    // board C: all 30 mines in rows 13-14; restart mid-fill first
    do_restart(); tick(1);
    clear_mines();
    for (int i = 13 * W; i < N; i++) mine_m[i] = 1;
    load_board();
    cx = 4'd0; cy = 4'd0; cell_click = 1'b1;
    @(negedge clk_pix); cell_click = 1'b0;
    tick(20);
    chk("midfill_busy", busy, 1);
    do_restart();
    chk("abort_busy", busy, 0); chk("abort_rev", revealed_count, 0); chk("abort_flag", flag_count, 0);
    chk("abort_addr", mem_addr, 0);
    nwr = 0;
    for (int i = 0; i < 40; i++) begin if (mem_we) nwr++; @(negedge clk_pix); end
    chk("abort_no_we", nwr, 0);
    m_valid = 1;

    m_valid = 0;
    restart_game = 1'b1; cell_click = 1'b1; cx = 4'd2; cy = 4'd2;
    @(negedge clk_pix);
    restart_game = 1'b0; cell_click = 1'b0;
    chk("restart_beats_click", busy, 0);
    tick(1); m_valid = 1;

    load_board();
    do_click(1, 0, 0, 5000);
    chk("won_rev_literal", revealed_count, 195); chk("won_flag", game_won, 1);
    do_click(1, 15, 14, 20);
    chk("won_x15_drop", busy_seen, 0);
    do_click(1, 3, 14, 20);
    chk("won_click_drop", busy_seen, 0);
    tick(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
